// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared state type and constants for the data SRAM responder
package data_sram_responder_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;
   localparam int CNT_W = 4;
   function automatic logic [31:0] win_offset(input logic [31:0] addr, input logic [31:0] base);
      return addr - base;
   endfunction
endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: memory-stage to data SRAM request/response bundle
interface data_sram_responder_if;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_cancel;
   logic [31:0] mem_rdata;
   logic        mem_stall;
   logic        mem_error;
   modport master (
      output mem_en, mem_wen, mem_addr, mem_wdata, mem_cancel,
      input  mem_rdata, mem_stall, mem_error
   );
   modport slave (
      input  mem_en, mem_wen, mem_addr, mem_wdata, mem_cancel,
      output mem_rdata, mem_stall, mem_error
   );
endinterface

// File: rtl/data_sram_responder_array.sv
// data_sram_responder_array: word RAM with synchronous byte-lane write and registered read
module data_sram_responder_array #(
   parameter int DEPTH_WORDS = 1024,
   localparam int IW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    wen,
   input  logic          re,
   input  logic [IW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_q;
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (we && wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      if (re) rd_q <= mem[idx];
   end
   assign rdata = rd_q;
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: multi-cycle data RAM responder with stall, cancel and window check
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic                  clk,
   input logic                  rst,
   data_sram_responder_if.slave bus
);
   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN : (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
   localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [3:0]       wen_q, wen_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             in_range_q, in_range_d;
   logic             zero_q, zero_d;
   logic [31:0]      off;
   logic             take, access, ram_we, ram_re;
   logic [31:0]      ram_rdata;
   data_sram_responder_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .we    (ram_we),
      .wen   (wen_q),
      .re    (ram_re),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );
   // zero_q masks the RAM read register: set by reset or an out-of-window access
   always_comb begin
      off = win_offset(bus.mem_addr, BASE_ADDR);
      take = state_q == ST_IDLE && bus.mem_en && !bus.mem_cancel;
      access = state_q == ST_WAIT && !bus.mem_cancel && cnt_q == '0;
      ram_we = access && in_range_q && |wen_q;
      ram_re = access && in_range_q && !(|wen_q);
      state_d = state_q;
      cnt_d = cnt_q;
      idx_d = take ? off[IW+1:2] : idx_q;
      wen_d = take ? bus.mem_wen : wen_q;
      wdata_d = take ? bus.mem_wdata : wdata_q;
      in_range_d = take ? off < WIN_BYTES : in_range_q;
      zero_d = access ? (!in_range_q || (zero_q && |wen_q)) : zero_q;
      case (state_q)
         ST_IDLE: begin
            state_d = take ? ST_WAIT : ST_IDLE;
            cnt_d = take ? CNT_W'(LAT - 1) : cnt_q;
         end
         ST_WAIT: begin
            state_d = bus.mem_cancel ? ST_IDLE : access ? ST_RESP : ST_WAIT;
            cnt_d = (!bus.mem_cancel && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   assign bus.mem_stall = state_q == ST_WAIT || take;
   assign bus.mem_error = state_q == ST_RESP && !in_range_q;
   assign bus.mem_rdata = zero_q ? '0 : ram_rdata;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         idx_q <= '0;
         wen_q <= '0;
         wdata_q <= '0;
         in_range_q <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         wen_q <= wen_d;
         wdata_q <= wdata_d;
         in_range_q <= in_range_d;
         zero_q <= zero_d;
      end
   end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: random requests vs. a word-array model, scoreboard checked on each response
module tb_data_sram_responder;
   localparam int DEPTH = 64;
   localparam int LAT = 2;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] WIN = 32'(DEPTH * 4);
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          len;
      string       tag;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   data_sram_responder_if bus();
   data_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mdl [DEPTH];
   logic [31:0] last_rd = '0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          run = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // a response is the first cycle stall drops after a run of stalled cycles
   always @(negedge clk) begin
      if (bus.mem_stall) begin
         run++;
         if (run == 40) chk("stall_timeout", run, LAT + 1);
      end else begin
         if (run > 0) begin
            if (sb.size() == 0) chk("unexpected_resp", run, 0);
            else begin
               mon_e = sb.pop_front();
               chk({mon_e.tag, "_rdata"}, bus.mem_rdata, mon_e.rdata);
               chk({mon_e.tag, "_error"}, 32'(bus.mem_error), 32'(mon_e.err));
               chk({mon_e.tag, "_stall_len"}, run, mon_e.len);
            end
         end else chk("error_idle", 32'(bus.mem_error), 0);
         run = 0;
      end
   end
   task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input int abort_at = 0, input bit abort_rst = 0, input string tag = "req");
      exp_t e;
      logic [31:0] off;
      int idx;
      off = addr - BASE;
      idx = int'(off >> 2);
      e.tag = tag;
      e.err = 1'b0;
      if (abort_at > 0) begin
         e.len = abort_rst ? abort_at : abort_at + 1;
         if (abort_rst) last_rd = '0;
         e.rdata = last_rd;
      end else if (off >= WIN) begin
         e.len = LAT + 1;
         e.err = 1'b1;
         last_rd = '0;
         e.rdata = '0;
      end else begin
         e.len = LAT + 1;
         if (wen != 4'b0000) begin
            for (int i = 0; i < 4; i++)
               if (wen[i]) mdl[idx][8*i +: 8] = wdata[8*i +: 8];
         end else last_rd = mdl[idx];
         e.rdata = last_rd;
      end
      sb.push_back(e);
      @(posedge clk); #1;
      bus.mem_en = 1'b1;
      bus.mem_wen = wen;
      bus.mem_addr = addr;
      bus.mem_wdata = wdata;
      bus.mem_cancel = 1'b0;
      for (int c = 1; c <= LAT + 1; c++) begin
         @(posedge clk); #1;
         if (c == abort_at) begin
            if (abort_rst) begin
               rst = 1'b1;
               bus.mem_en = 1'b0;
               @(posedge clk); #1;
               rst = 1'b0;
            end else begin
               bus.mem_cancel = 1'b1;
               @(posedge clk); #1;
               bus.mem_cancel = 1'b0;
               bus.mem_en = 1'b0;
            end
            break;
         end
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.mem_en = 1'b0;
         bus.mem_cancel = 1'b0;
      end
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [31:0] a;
      logic [3:0] w;
      int ab;
      bus.mem_en = 1'b0;
      bus.mem_wen = '0;
      bus.mem_addr = '0;
      bus.mem_wdata = '0;
      bus.mem_cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rdata", bus.mem_rdata, 0);
      chk("reset_stall", 32'(bus.mem_stall), 0);
      chk("reset_error", 32'(bus.mem_error), 0);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         req(4'hf, BASE + 32'(4 * i), i == 0 ? 32'hDEAD_BEEF : i == 4 ? 32'h1111_1111 : $urandom, 0, 0, "preload");
      idle(2);
      req(4'h0, BASE, '0, 0, 0, "rd_word0");
      idle(1);
      req(4'b0100, BASE + 32'h10, 32'h00AB_0000, 0, 0, "lane_wr");
      req(4'h0, BASE + 32'h10, '0, 0, 0, "lane_rd");
      req(4'h0, BASE + WIN, '0, 0, 0, "oob_hi");
      req(4'h0, BASE - 32'h4, '0, 0, 0, "oob_lo");
      req(4'hf, BASE + WIN + 32'h8, 32'hBAD0_BAD0, 0, 0, "oob_wr");
      req(4'h0, BASE + 32'h8, '0, 0, 0, "rd_after_oob");
      req(4'hf, BASE + 32'h20, 32'hCAFE_F00D, LAT, 0, "cancel_last");
      req(4'h0, BASE + 32'h20, '0, 0, 0, "rd_after_cancel");
      req(4'hf, BASE + 32'h24, 32'h0BAD_CAFE, 1, 0, "cancel_first");
      req(4'h0, BASE + 32'h24, '0, 0, 0, "rd_after_cancel1");
      @(posedge clk); #1;
      bus.mem_en = 1'b1;
      bus.mem_cancel = 1'b1;
      bus.mem_wen = 4'hf;
      bus.mem_addr = BASE + 32'h28;
      bus.mem_wdata = 32'h7777_7777;
      idle(1);
      req(4'h0, BASE + 32'h28, '0, 0, 0, "rd_after_idle_cancel");
      req(4'hf, BASE + 32'h2c, 32'h1234_5678, 0, 0, "b2b_st");
      req(4'h0, BASE + 32'h2c, '0, 0, 0, "b2b_ld");
      req(4'hf, BASE + 32'h30, 32'h5555_AAAA, 1, 1, "rst_mid");
      idle(2);
      req(4'h0, BASE + 32'h30, '0, 0, 0, "rd_after_rst");
      repeat (150) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, int'(WIN) + 31));
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT) : 0;
         req(w, a, $urandom, ab, 0, "rnd");
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(4);
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
